// File: rtl/store_pack_buffer_if.sv
// Store-side and data-memory-side signals of the store pack buffer.
// Optional macro STORE_LD_HAZARD_EN adds the load-hazard lookup signals.
interface store_pack_buffer_if;
  logic        st_valid;
  logic [1:0]  st_type;
  logic [31:0] st_addr;
  logic [31:0] st_wdata;
  logic        st_stall;
  logic        st_misalign;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack;
`ifdef STORE_LD_HAZARD_EN
  logic        ld_valid;
  logic [31:0] ld_addr;
  logic        ld_hazard;

  modport slave (
    input  st_valid, st_type, st_addr, st_wdata, mem_ack, ld_valid, ld_addr,
    output st_stall, st_misalign, mem_req, mem_addr, mem_be, mem_wdata, ld_hazard
  );
  modport master (
    output st_valid, st_type, st_addr, st_wdata, mem_ack, ld_valid, ld_addr,
    input  st_stall, st_misalign, mem_req, mem_addr, mem_be, mem_wdata, ld_hazard
  );
`else
  modport slave (
    input  st_valid, st_type, st_addr, st_wdata, mem_ack,
    output st_stall, st_misalign, mem_req, mem_addr, mem_be, mem_wdata
  );
  modport master (
    output st_valid, st_type, st_addr, st_wdata, mem_ack,
    input  st_stall, st_misalign, mem_req, mem_addr, mem_be, mem_wdata
  );
`endif
endinterface

// File: rtl/store_pack_buffer.sv
// Narrows SW/SH/SB stores to byte lanes and queues them in a DEPTH-entry FIFO draining to DM.
// Optional macro STORE_LD_HAZARD_EN adds a load-address hazard check against queued stores.
module store_pack_buffer #(
  parameter int DEPTH = 2
) (
  input logic               clk,
  input logic               reset,
  store_pack_buffer_if.slave bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [29:0]   addr_q [DEPTH];
  logic [3:0]    be_q   [DEPTH];
  logic [31:0]   data_q [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          full, empty, misalign, push, pop;
  logic [3:0]    pk_be;
  logic [31:0]   pk_data;
  logic [1:0]    a;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign a     = bus.st_addr[1:0];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  always_comb begin
    pk_be    = 4'b0000;
    pk_data  = 32'h0;
    misalign = 1'b0;
    case (bus.st_type)
      2'b00: begin
        pk_be    = 4'b1111;
        pk_data  = bus.st_wdata;
        misalign = (a != 2'b00);
      end
      2'b01: begin
        pk_be    = a[1] ? 4'b1100 : 4'b0011;
        pk_data  = {2{bus.st_wdata[15:0]}};
        misalign = a[0];
      end
      2'b10: begin
        pk_be    = 4'b0001 << a;
        pk_data  = {4{bus.st_wdata[7:0]}};
      end
      default: ;
    endcase
  end

  // Stall wins over misalign so a full buffer never reports a drop it did not make.
  assign bus.st_stall    = bus.st_valid && full;
  assign bus.st_misalign = bus.st_valid && !full && misalign;
  assign push = bus.st_valid && !full && !misalign && (bus.st_type != 2'b11);
  assign pop  = !empty && bus.mem_ack;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        addr_q[wr_ptr] <= bus.st_addr[31:2];
        be_q[wr_ptr]   <= pk_be;
        data_q[wr_ptr] <= pk_data;
        wr_ptr         <= ptr_inc(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign bus.mem_req   = !empty;
  assign bus.mem_addr  = empty ? 32'h0 : {addr_q[rd_ptr], 2'b00};
  assign bus.mem_be    = empty ? 4'h0 : be_q[rd_ptr];
  assign bus.mem_wdata = empty ? 32'h0 : data_q[rd_ptr];

`ifdef STORE_LD_HAZARD_EN
  logic [DEPTH-1:0] vld;
  logic             hit;
  logic             unused_ld_low;

  assign unused_ld_low = ^bus.ld_addr[1:0];

  // Push never lands on the head slot while a pop is possible, so set/clear cannot collide.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld <= '0;
    end else begin
      if (pop)  vld[rd_ptr] <= 1'b0;
      if (push) vld[wr_ptr] <= 1'b1;
    end
  end

  always_comb begin
    hit = push && (bus.st_addr[31:2] == bus.ld_addr[31:2]);
    for (int i = 0; i < DEPTH; i++) begin
      if (vld[i] && (addr_q[i] == bus.ld_addr[31:2])) hit = 1'b1;
    end
  end

  assign bus.ld_hazard = bus.ld_valid && hit;
`endif
endmodule

// File: tb/tb_store_pack_buffer.sv
// Self-checking bench for store_pack_buffer: queue-based reference model plus directed literal checks.
module tb_store_pack_buffer;
  localparam int DEPTH = 2;
  localparam logic [1:0] SW = 2'b00, SH = 2'b01, SB = 2'b10, RSV = 2'b11;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] data;
  } entry_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   errors = 0;
  int   checks = 0;
  bit   armed = 1'b0;
  entry_t q[$];

  store_pack_buffer_if bus ();

  store_pack_buffer #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit is_mis(input logic [1:0] t, input logic [31:0] ad);
    return (t == SW && ad[1:0] != 2'b00) || (t == SH && ad[0]);
  endfunction

  function automatic entry_t pack(input logic [1:0] t, input logic [31:0] ad, input logic [31:0] w);
    entry_t e;
    e.addr = {ad[31:2], 2'b00};
    if (t == SW) begin
      e.be = 4'hF; e.data = w;
    end else if (t == SH) begin
      e.be = ad[1] ? 4'hC : 4'h3; e.data = {2{w[15:0]}};
    end else begin
      e.be = 4'(1 << ad[1:0]); e.data = {4{w[7:0]}};
    end
    return e;
  endfunction

  function automatic bit will_push();
    return bus.st_valid && q.size() < DEPTH && !is_mis(bus.st_type, bus.st_addr)
           && bus.st_type != RSV;
  endfunction

  // Reference model: advance the queue on every clock edge.
  always @(posedge clk) begin
    if (reset) begin
      q.delete();
      armed = 1'b1;
    end else begin
      bit push_m, pop_m;
      push_m = will_push();
      pop_m  = q.size() > 0 && bus.mem_ack;
      if (pop_m) void'(q.pop_front());
      if (push_m) q.push_back(pack(bus.st_type, bus.st_addr, bus.st_wdata));
    end
  end

  // Compare process: every negedge, all outputs against the model.
  always @(negedge clk) begin
    if (armed) begin
      int n;
      bit full_m;
      n = q.size();
      full_m = (n == DEPTH);
      check("mem_req", {31'b0, bus.mem_req}, {31'b0, n != 0});
      check("mem_addr", bus.mem_addr, n != 0 ? q[0].addr : 32'h0);
      check("mem_be", {28'b0, bus.mem_be}, {28'b0, n != 0 ? q[0].be : 4'h0});
      check("mem_wdata", bus.mem_wdata, n != 0 ? q[0].data : 32'h0);
      check("st_stall", {31'b0, bus.st_stall}, {31'b0, bus.st_valid && full_m});
      check("st_misalign", {31'b0, bus.st_misalign},
            {31'b0, bus.st_valid && !full_m && is_mis(bus.st_type, bus.st_addr)});
`ifdef STORE_LD_HAZARD_EN
      begin
        bit hz;
        hz = will_push() && bus.st_addr[31:2] == bus.ld_addr[31:2];
        foreach (q[i]) if (q[i].addr[31:2] == bus.ld_addr[31:2]) hz = 1'b1;
        check("ld_hazard", {31'b0, bus.ld_hazard}, {31'b0, bus.ld_valid && hz});
      end
`endif
    end
  end

  task automatic drive(input bit v, input logic [1:0] t, input logic [31:0] ad,
                       input logic [31:0] w, input bit k);
    bus.st_valid = v;
    bus.st_type  = t;
    bus.st_addr  = ad;
    bus.st_wdata = w;
    bus.mem_ack  = k;
  endtask

  task automatic idle(input bit k);
    drive(1'b0, SW, 32'h0, 32'h0, k);
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  initial begin
    idle(1'b0);
`ifdef STORE_LD_HAZARD_EN
    bus.ld_valid = 1'b0;
    bus.ld_addr  = 32'h0;
`endif
    cyc(); cyc();
    reset = 1'b0;
    check("rst_req", {31'b0, bus.mem_req}, 32'h0);
    check("rst_addr", bus.mem_addr, 32'h0);

    // SW word store, one-cycle latency
    drive(1'b1, SW, 32'h10, 32'h12345678, 1'b0); cyc(); idle(1'b0);
    check("sw_req", {31'b0, bus.mem_req}, 32'h1);
    check("sw_addr", bus.mem_addr, 32'h10);
    check("sw_be", {28'b0, bus.mem_be}, 32'hF);
    check("sw_data", bus.mem_wdata, 32'h12345678);
    idle(1'b1); cyc(); idle(1'b0);
    check("sw_drained", {31'b0, bus.mem_req}, 32'h0);

    // SB lane packing, then SH pushed while SB is acked
    drive(1'b1, SB, 32'h23, 32'hAABBCCDD, 1'b0); cyc(); idle(1'b0);
    check("sb_addr", bus.mem_addr, 32'h20);
    check("sb_be", {28'b0, bus.mem_be}, 32'h8);
    check("sb_data", bus.mem_wdata, 32'hDDDDDDDD);
    drive(1'b1, SH, 32'h22, 32'hAABBCCDD, 1'b1); cyc(); idle(1'b0);
    check("sh_be", {28'b0, bus.mem_be}, 32'hC);
    check("sh_data", bus.mem_wdata, 32'hCCDDCCDD);
    check("sh_req", {31'b0, bus.mem_req}, 32'h1);
    idle(1'b1); cyc(); idle(1'b0);

    // Fill, stall, single ack frees one slot
    drive(1'b1, SW, 32'h100, 32'h1, 1'b0); cyc();
    drive(1'b1, SW, 32'h104, 32'h2, 1'b0); cyc();
    drive(1'b1, SW, 32'h108, 32'h3, 1'b0); #1;
    check("full_stall", {31'b0, bus.st_stall}, 32'h1);
    cyc();
    check("full_stall_hold", {31'b0, bus.st_stall}, 32'h1);
    bus.mem_ack = 1'b1; #1;
    check("full_ack_no_comb", {31'b0, bus.st_stall}, 32'h1);
    cyc();
    bus.mem_ack = 1'b0; #1;
    check("stall_release", {31'b0, bus.st_stall}, 32'h0);
    check("head_after_ack", bus.mem_addr, 32'h100 + 32'h4);
    cyc(); idle(1'b1);
    check("third_head", bus.mem_addr, 32'h104);
    cyc();
    check("third_next", bus.mem_addr, 32'h108);
    check("third_data", bus.mem_wdata, 32'h3);
    cyc(); idle(1'b0);
    check("fill_drained", {31'b0, bus.mem_req}, 32'h0);

    // Misaligned stores are dropped; aligned SB at the same address is taken
    drive(1'b1, SW, 32'h11, 32'h9, 1'b0); #1;
    check("sw_mis", {31'b0, bus.st_misalign}, 32'h1);
    cyc();
    drive(1'b1, SH, 32'h13, 32'h9, 1'b0); #1;
    check("sh_mis", {31'b0, bus.st_misalign}, 32'h1);
    check("mis_no_req", {31'b0, bus.mem_req}, 32'h0);
    cyc();
    drive(1'b1, SB, 32'h13, 32'h55, 1'b0); #1;
    check("sb_ok", {31'b0, bus.st_misalign}, 32'h0);
    cyc(); idle(1'b0);
    check("sb13_addr", bus.mem_addr, 32'h10);
    check("sb13_be", {28'b0, bus.mem_be}, 32'h8);
    check("sb13_data", bus.mem_wdata, 32'h55555555);
    drive(1'b1, SW, 32'h40, 32'h4, 1'b0); cyc();
    drive(1'b1, SW, 32'h11, 32'h5, 1'b0); #1;
    check("prio_stall", {31'b0, bus.st_stall}, 32'h1);
    check("prio_mis", {31'b0, bus.st_misalign}, 32'h0);

    // Reset discards a full queue
    idle(1'b0); reset = 1'b1; cyc(); reset = 1'b0;
    check("rst_mid_req", {31'b0, bus.mem_req}, 32'h0);

    // Reserved type is ignored
    drive(1'b1, RSV, 32'h50, 32'h6, 1'b0); cyc(); idle(1'b0);
    check("rsv_ignored", {31'b0, bus.mem_req}, 32'h0);

    // Order across several pointer wraps
    for (int r = 0; r < 4; r++) begin
      drive(1'b1, SW, 32'h200 + 32'(r * 16), 32'(r), 1'b0); cyc();
      drive(1'b1, SH, 32'h206 + 32'(r * 16), 32'hBEEF0000 + 32'(r), 1'b0); cyc();
      idle(1'b1);
      check("wrap_head", bus.mem_addr, 32'h200 + 32'(r * 16));
      cyc();
      check("wrap_second", bus.mem_addr, 32'h204 + 32'(r * 16));
      check("wrap_be", {28'b0, bus.mem_be}, 32'hC);
      cyc(); idle(1'b0);
    end

`ifdef STORE_LD_HAZARD_EN
    drive(1'b1, SB, 32'h23, 32'h11, 1'b0); cyc(); idle(1'b0);
    bus.ld_valid = 1'b1; bus.ld_addr = 32'h21; #1;
    check("hz_hit", {31'b0, bus.ld_hazard}, 32'h1);
    bus.ld_addr = 32'h24; #1;
    check("hz_miss", {31'b0, bus.ld_hazard}, 32'h0);
    drive(1'b1, SW, 32'h24, 32'h7, 1'b0); #1;
    check("hz_enq", {31'b0, bus.ld_hazard}, 32'h1);
    cyc(); idle(1'b0); bus.ld_valid = 1'b0;
    reset = 1'b1; cyc(); reset = 1'b0;
`endif

    cyc(); cyc();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
